// File: rtl/mem_port_arbiter.sv
// Arbitrates one 64-bit memory port between the loader (0), CPU data (1) and CPU fetch (2).
// Loader has absolute priority; CPU requesters alternate round-robin and are frozen by halt.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic [2:0]             req,
  input  logic [2:0]             we,
  input  logic [2:0][ADDR_W-1:0] addr,
  input  logic [2:0][63:0]       wdata,
  output logic [2:0]             gnt,
  output logic [2:0]             done,
  output logic [63:0]            rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [63:0]            mem_wdata,
  input  logic [63:0]            mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt;
  logic             sel_valid;
  logic             first;
  logic [CNT_W-1:0] count;
  logic             last_two;

  // last_two set means requester 2 was the most recent CPU-side winner.
  always_comb begin
    sel_valid = 1'b0;
    sel_nxt   = 2'd0;
    if (req[0]) begin
      sel_valid = 1'b1;
      sel_nxt   = 2'd0;
    end else if (!halt && req[1] && (!req[2] || last_two)) begin
      sel_valid = 1'b1;
      sel_nxt   = 2'd1;
    end else if (!halt && req[2]) begin
      sel_valid = 1'b1;
      sel_nxt   = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sel_valid) state_nxt = S_ACCESS;
      S_ACCESS: if (count == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel       <= 2'd0;
      first     <= 1'b0;
      count     <= '0;
      last_two  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      first <= 1'b0;
      if (state == S_IDLE && sel_valid) begin
        sel       <= sel_nxt;
        first     <= 1'b1;
        count     <= CNT_W'(MEM_LAT - 1);
        mem_we    <= we[sel_nxt];
        mem_addr  <= addr[sel_nxt];
        mem_wdata <= wdata[sel_nxt];
      end
      if (state == S_ACCESS) begin
        if (count != '0)  count <= count - 1'b1;
        else if (!mem_we) rdata <= mem_rdata;
      end
      if (state == S_DONE && sel != 2'd0) last_two <= sel[1];
    end
  end

  always_comb begin
    gnt    = '0;
    done   = '0;
    mem_en = 1'b0;
    case (state)
      S_ACCESS: begin
        mem_en = 1'b1;
        if (first) gnt[sel] = 1'b1;
      end
      S_DONE:   done[sel] = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model schedules expected grants,
// completions and bus windows; a negedge monitor compares them with the DUT.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 64;
  localparam int MEM_LAT = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   halt = 1'b0;
  logic [2:0]             req = '0;
  logic [2:0]             we = '0;
  logic [2:0][ADDR_W-1:0] addr = '0;
  logic [2:0][63:0]       wdata = '0;
  logic [2:0]             gnt, done;
  logic [63:0]            rdata;
  logic                   mem_en, mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [63:0]            mem_wdata, mem_rdata;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .halt(halt), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_fn(input logic [ADDR_W-1:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0000_0000_0000_DEAD;
  endfunction

  assign mem_rdata = mem_en ? mem_fn(mem_addr) : 64'h0;

  typedef struct {int cyc; int who; logic [63:0] data;} ev_t;
  ev_t gq[$];
  ev_t dq[$];

  int                free_at = 0;
  bit                prefer_two = 1'b0;
  logic [63:0]       exp_rdata = '0;
  int                bus_from = -1;
  int                bus_to = -2;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [63:0]       bus_wdata;

  task automatic model_flush();
    gq.delete();
    dq.delete();
    free_at    = 0;
    prefer_two = 1'b0;
    exp_rdata  = '0;
    bus_from   = -1;
    bus_to     = -2;
  endtask

  // One access occupies the port for MEM_LAT+2 cycles starting at the arbitration edge.
  task automatic model_step();
    int w;
    if (!reset) begin
      model_flush();
      return;
    end
    if (cyc < free_at) return;
    w = -1;
    if (req[0]) w = 0;
    else if (!halt) begin
      if (req[1] && req[2]) w = prefer_two ? 2 : 1;
      else if (req[1])      w = 1;
      else if (req[2])      w = 2;
    end
    if (w < 0) return;
    gq.push_back('{cyc + 1, w, 64'h0});
    if (!we[w]) exp_rdata = mem_fn(addr[w]);
    dq.push_back('{cyc + MEM_LAT + 1, w, exp_rdata});
    bus_from  = cyc + 1;
    bus_to    = cyc + MEM_LAT;
    bus_we    = we[w];
    bus_addr  = addr[w];
    bus_wdata = wdata[w];
    free_at   = cyc + MEM_LAT + 2;
    if (w == 1) prefer_two = 1'b1;
    else if (w == 2) prefer_two = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        logic [2:0]  eg, ed;
        logic [63:0] er;
        bit          en_exp;
        eg = '0; ed = '0; er = '0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          eg = 3'b001 << gq[0].who;
          void'(gq.pop_front());
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          ed = 3'b001 << dq[0].who;
          er = dq[0].data;
          void'(dq.pop_front());
        end
        if (eg != 0 || gnt != 0) begin
          vectors++;
          if (gnt !== eg) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, eg);
          end
        end
        if (ed != 0 || done != 0) begin
          vectors++;
          if (done !== ed || (ed != 0 && rdata !== er)) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b rdata=%h want=%b rdata=%h", cyc, done, rdata, ed, er);
          end
        end
        en_exp = (cyc >= bus_from && cyc <= bus_to);
        vectors++;
        if (mem_en !== en_exp ||
            (en_exp && {mem_we, mem_addr, mem_wdata} !== {bus_we, bus_addr, bus_wdata})) begin
          errors++;
          $display("FAIL bus cyc=%0d got en=%b we=%b a=%h d=%h want en=%b we=%b a=%h d=%h",
                   cyc, mem_en, mem_we, mem_addr, mem_wdata, en_exp, bus_we, bus_addr, bus_wdata);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({gnt, done, mem_en, mem_we, rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL %s got gnt=%b done=%b en=%b we=%b rdata=%h a=%h d=%h want all zero",
               tag, gnt, done, mem_en, mem_we, rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic wait_done(input int i);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done[i]) begin
        req[i] = 1'b0;
        return;
      end
    end
    vectors++;
    errors++;
    $display("FAIL timeout done[%0d] got=none want=pulse", i);
  endtask

  task automatic drive_rand(input int p0, input int p12);
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        if (done[i] || $urandom_range(99) < 3) req[i] = 1'b0;
        if ($urandom_range(99) < 20) begin
          we[i]    = 1'($urandom_range(1));
          addr[i]  = {$urandom, $urandom};
          wdata[i] = {$urandom, $urandom};
        end
      end else if ($urandom_range(99) < ((i == 0) ? p0 : p12)) begin
        req[i]   = 1'b1;
        we[i]    = 1'($urandom_range(1));
        addr[i]  = {$urandom, $urandom};
        wdata[i] = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    model_flush();
    #1 check_reset_outputs("reset_state");
    tick(); tick();
    reset = 1'b1;
    tick();

    // single read on fetch port
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 64'h10;
    wait_done(2);
    // single write on data port
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 64'h40; wdata[1] = 64'h1234;
    wait_done(1);
    tick();

    // all three held; loader leaves after first service
    req = 3'b111; we = 3'b000;
    addr[0] = 64'h100; addr[1] = 64'h200; addr[2] = 64'h300;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done[0]) req[0] = 1'b0;
    end
    req = '0;
    tick(); tick();

    // halt blocks CPU side, loader still served, release lets 1 through
    halt = 1'b1; req = 3'b110;
    repeat (10) tick();
    req[0] = 1'b1; addr[0] = 64'h8;
    wait_done(0);
    halt = 1'b0;
    repeat (8) begin
      tick();
      if (done[1]) req[1] = 1'b0;
      if (done[2]) req[2] = 1'b0;
    end
    req = '0;
    tick(); tick();

    // fetch dropped after grant still completes
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 64'h77;
    tick(); tick();
    req[2] = 1'b0;
    repeat (6) tick();

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(99) < 2) halt = ~halt;
      drive_rand(8, 30);
      tick();
    end
    halt = 1'b0;

    for (int r = 0; r < 5; r++) begin
      for (int n = 0; n < 50 && !mem_en; n++) begin
        drive_rand(10, 40);
        tick();
      end
      #2 reset = 1'b0;
      model_flush();
      #1 check_reset_outputs("reset_mid_access");
      tick();
      reset = 1'b1;
      for (int n = 0; n < 40; n++) begin
        drive_rand(10, 40);
        tick();
      end
    end

    req = '0;
    repeat (12) tick();
    vectors++;
    if (gq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain got pending gnt=%0d done=%0d want 0", gq.size(), dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
